// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready command into one APB transfer and returns a one-cycle response.
// Optional access timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef APB_MASTER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic              pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverror
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;

  // Gated with reset so no command can be seen as accepted while the block is held in reset.
  assign cmd_ready = rst && (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pselx     <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      wait_cnt    <= 8'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            pselx  <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= 8'd0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            if (!pwrite) rsp_rdata <= prdata;
            rsp_error <= pslverror;
            rsp_valid <= 1'b1;
            pselx     <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            // This edge makes the TIMEOUT-th wait cycle: abort, read data left untouched.
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end
        default: begin
          pselx   <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master; the timeout scenario runs when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_error, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          pselx, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverror;

  int checks = 0;
  int failures = 0;

  apb_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverror(pslverror)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverror = 1'b0;
    cyc(); cyc();
    checks++;
    if ({pselx, penable, pwrite, paddr, pwdata} !== {3'b000, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_apb: got %b %b %b %h %h exp 0 0 0 0 0", pselx, penable, pwrite, paddr, pwdata);
    end
    checks++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata, cmd_ready} !== {3'b000, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_rsp: got v=%b e=%b t=%b d=%h rdy=%b exp all 0", rsp_valid, rsp_error, rsp_timeout, rsp_rdata, cmd_ready);
    end
    #3 rst = 1'b1;
    cyc();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b exp 1", cmd_ready);
    end
  endtask

  task automatic test_zero_wait_write();
    pready = 1'b1;
    prdata = 32'hA5A5A5A5;
    issue(1'b1, 32'd1215, 32'hDEADBEEF);
    cyc();
    cmd_valid = 1'b0;
    checks++;
    if ({pselx, penable, pwrite, paddr, pwdata, cmd_ready, rsp_valid} !== {3'b101, 32'd1215, 32'hDEADBEEF, 2'b00}) begin
      failures++;
      $display("FAIL wr_setup: got psel=%b pen=%b pw=%b a=%0d d=%h rdy=%b rv=%b exp 1 0 1 1215 deadbeef 0 0",
               pselx, penable, pwrite, paddr, pwdata, cmd_ready, rsp_valid);
    end
    cyc();
    checks++;
    if ({pselx, penable, paddr, pwdata, rsp_valid} !== {2'b11, 32'd1215, 32'hDEADBEEF, 1'b0}) begin
      failures++;
      $display("FAIL wr_access: got psel=%b pen=%b a=%0d d=%h rv=%b exp 1 1 1215 deadbeef 0", pselx, penable, paddr, pwdata, rsp_valid);
    end
    cyc();
    checks++;
    if ({rsp_valid, rsp_error, rsp_timeout, pselx, penable, cmd_ready} !== 6'b100001) begin
      failures++;
      $display("FAIL wr_done: got rv=%b e=%b t=%b psel=%b pen=%b rdy=%b exp 1 0 0 0 0 1", rsp_valid, rsp_error, rsp_timeout, pselx, penable, cmd_ready);
    end
    checks++;
    if ({paddr, pwdata, pwrite, rsp_rdata} !== {32'd1215, 32'hDEADBEEF, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL wr_retain: got a=%0d d=%h pw=%b rd=%h exp 1215 deadbeef 1 00000000", paddr, pwdata, pwrite, rsp_rdata);
    end
    cyc();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_pulse_width: got rsp_valid=%b exp 0", rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    pready = 1'b0;
    issue(1'b0, 32'd1221, 32'h0);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      prdata = 32'hBAD00000 + DW'(i);
      pslverror = 1'b1;
      cyc();
      checks++;
      if ({pselx, penable, pwrite, paddr, rsp_valid} !== {3'b110, 32'd1221, 1'b0}) begin
        failures++;
        $display("FAIL rd_wait%0d: got psel=%b pen=%b pw=%b a=%0d rv=%b exp 1 1 0 1221 0", i, pselx, penable, pwrite, paddr, rsp_valid);
      end
    end
    pready = 1'b1; pslverror = 1'b0; prdata = 32'h12345678;
    cyc();
    checks++;
    if ({rsp_valid, rsp_error, rsp_rdata, pselx} !== {2'b10, 32'h12345678, 1'b0}) begin
      failures++;
      $display("FAIL rd_done: got rv=%b e=%b d=%h psel=%b exp 1 0 12345678 0", rsp_valid, rsp_error, rsp_rdata, pselx);
    end
    cyc();
  endtask

  task automatic test_slave_error();
    pready = 1'b1; pslverror = 1'b1; prdata = 32'hCAFEF00D;
    issue(1'b0, 32'd2047, 32'h0);
    cyc();
    cmd_valid = 1'b0;
    cyc(); cyc();
    checks++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {3'b110, 32'hCAFEF00D}) begin
      failures++;
      $display("FAIL slverr: got rv=%b e=%b t=%b d=%h exp 1 1 0 cafef00d", rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
    end
    pslverror = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int last = -1;
    int low = 0;
    logic hs;
    pready = 1'b1;
    issue(1'b1, 32'd2047, 32'h1000);
    for (int n = 0; n < 30 && k < 5; n++) begin
      hs = cmd_ready;
      cyc();
      if (hs) begin
        checks++;
        if ({pselx, paddr, pwdata} !== {1'b1, 32'd2047 + AW'(k), 32'h1000 + DW'(k)}) begin
          failures++;
          $display("FAIL b2b_addr%0d: got psel=%b a=%0d d=%h exp 1 %0d %h", k, pselx, paddr, pwdata, 2047 + k, 32'h1000 + k);
        end
        if (k > 0) begin
          checks++;
          if (n - last != 3 || low != 1) begin
            failures++;
            $display("FAIL b2b_spacing%0d: got gap=%0d low=%0d exp 3 1", k, n - last, low);
          end
        end
        last = n; low = 0; k++;
        cmd_addr = 32'd2047 + AW'(k);
        cmd_wdata = 32'h1000 + DW'(k);
        if (k == 5) cmd_valid = 1'b0;
      end else if (!pselx) begin
        low++;
      end
    end
    checks++;
    if (k != 5) begin
      failures++;
      $display("FAIL b2b_count: got %0d handshakes exp 5", k);
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_reset_mid();
    pready = 1'b0;
    issue(1'b0, 32'd100, 32'h0);
    cyc();
    cmd_valid = 1'b0;
    cyc(); cyc();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({pselx, penable, paddr, rsp_valid, cmd_ready} !== {2'b00, 32'd0, 2'b00}) begin
      failures++;
      $display("FAIL reset_mid_async: got psel=%b pen=%b a=%0d rv=%b rdy=%b exp 0 0 0 0 0", pselx, penable, paddr, rsp_valid, cmd_ready);
    end
    cyc();
    #3 rst = 1'b1;
    pready = 1'b1;
    cyc();
    checks++;
    if ({rsp_valid, pselx, cmd_ready} !== 3'b001) begin
      failures++;
      $display("FAIL reset_mid_quiet: got rv=%b psel=%b rdy=%b exp 0 0 1", rsp_valid, pselx, cmd_ready);
    end
    prdata = 32'h0BADCAFE;
    issue(1'b0, 32'd1221, 32'h0);
    cyc();
    cmd_valid = 1'b0;
    cyc(); cyc();
    checks++;
    if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 32'h0BADCAFE}) begin
      failures++;
      $display("FAIL reset_mid_fresh: got rv=%b e=%b d=%h exp 1 0 0badcafe", rsp_valid, rsp_error, rsp_rdata);
    end
    cyc();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    pready = 1'b0;
    prdata = 32'h55555555;
    issue(1'b0, 32'd300, 32'h0);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    for (int i = 1; i <= 15; i++) begin
      cyc();
      checks++;
      if ({rsp_valid, pselx, penable} !== 3'b011) begin
        failures++;
        $display("FAIL to_wait%0d: got rv=%b psel=%b pen=%b exp 0 1 1", i, rsp_valid, pselx, penable);
      end
    end
    cyc();
    checks++;
    if ({rsp_valid, rsp_error, rsp_timeout, pselx, penable, rsp_rdata} !== {5'b11100, 32'h0BADCAFE}) begin
      failures++;
      $display("FAIL to_abort: got rv=%b e=%b t=%b psel=%b pen=%b d=%h exp 1 1 1 0 0 0badcafe",
               rsp_valid, rsp_error, rsp_timeout, pselx, penable, rsp_rdata);
    end
    pready = 1'b1;
    issue(1'b1, 32'd301, 32'h77);
    cyc();
    cmd_valid = 1'b0;
    cyc(); cyc();
    checks++;
    if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b100) begin
      failures++;
      $display("FAIL to_recover: got rv=%b e=%b t=%b exp 1 0 0", rsp_valid, rsp_error, rsp_timeout);
    end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait_write();
    test_read_wait();
    test_slave_error();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
